// File: rtl/addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor.
//   state_t : controller states (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size the bit counter
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2 of value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fa.sv
// Full adder built from two half adders and an OR.
//   x, y : input bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of x, y, cin)
module fa (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s0_s;
    logic c0_s;
    logic c1_s;

    ha u_ha0 (.x(x),    .y(y),   .s(s0_s), .c(c0_s));
    ha u_ha1 (.x(s0_s), .y(cin), .s(s),    .c(c1_s));

    // The two half-adder carries can never both be 1, so OR forms the majority.
    assign cout = c0_s | c1_s;

endmodule

// File: rtl/ha.sv
// Half adder.
//   x, y : input bits
//   s    : sum bit (x ^ y)
//   c    : carry bit (x & y)
module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);

    assign s = x ^ y;
    assign c = x & y;

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: WIDTH-bit operands processed LSB-first, one
// bit per clock, through a single full-adder cell and a carry flop.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   start    : request, accepted when idle or in the done cycle
//   sub      : 1 = a - b (only when SUB_EN != 0), 0 = a + b
//   a, b     : operands, latched on acceptance
//   busy     : high while bits are being processed
//   done     : one-cycle pulse when sum/carry/overflow are updated
//   sum      : result, modulo 2^WIDTH, held until the next completion
//   carry    : carry out of MSB (for subtract, 1 = no borrow)
//   overflow : signed overflow (carry into MSB XOR carry out of MSB)
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SUB_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             c_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic             ovf_r;

    logic             sub_eff_s;
    logic             bit_s;
    logic             cout_s;

    // Subtraction is a + ~b + 1: b is inverted at load and the +1 enters
    // through the initial carry.
    assign sub_eff_s = (SUB_EN != 0) ? sub : 1'b0;

    fa u_fa (
        .x   (a_sh_r[0]),
        .y   (b_sh_r[0]),
        .cin (c_r),
        .s   (bit_s),
        .cout(cout_s)
    );

    // Controller, operand/result shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b ^ {WIDTH{sub_eff_s}};
                        c_r     <= sub_eff_s;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r  <= {bit_s, res_r[WIDTH-1:1]};
                    c_r    <= cout_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (cnt_r == LAST_BIT) begin
                        // MSB cycle: c_r is the carry into the MSB, cout_s the
                        // carry out, so overflow is formed directly here.
                        sum_r   <= {bit_s, res_r[WIDTH-1:1]};
                        carry_r <= cout_s;
                        ovf_r   <= c_r ^ cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign carry    = carry_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub. Three instances share clock and
// reset: index 0 = WIDTH 8 with subtract, 1 = WIDTH 8 add-only, 2 = WIDTH 2.
// Expected results come from plain integer arithmetic in ref_model.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start;
    logic [2:0] sub;
    logic [7:0] a8, b8, a8n, b8n, sum8, sum8n;
    logic [1:0] a2, b2, sum2;
    logic [2:0] busy, done, carry, ovf;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_sum [3];

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .SUB_EN(1)) u_add8 (
        .clk(clk), .rst(rst), .start(start[0]), .sub(sub[0]), .a(a8), .b(b8),
        .busy(busy[0]), .done(done[0]), .sum(sum8), .carry(carry[0]), .overflow(ovf[0]));

    serial_addsub #(.WIDTH(8), .SUB_EN(0)) u_add8n (
        .clk(clk), .rst(rst), .start(start[1]), .sub(sub[1]), .a(a8n), .b(b8n),
        .busy(busy[1]), .done(done[1]), .sum(sum8n), .carry(carry[1]), .overflow(ovf[1]));

    serial_addsub #(.WIDTH(2), .SUB_EN(1)) u_add2 (
        .clk(clk), .rst(rst), .start(start[2]), .sub(sub[2]), .a(a2), .b(b2),
        .busy(busy[2]), .done(done[2]), .sum(sum2), .carry(carry[2]), .overflow(ovf[2]));

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int which);
        return (which == 2) ? 2 : 8;
    endfunction

    // Returns {overflow, carry, sum[31:0]} from unsigned and signed arithmetic.
    function automatic logic [33:0] ref_model(input int w, input longint ua, input longint ub, input bit s);
        longint m, sa, sb, ru, rs;
        bit c, o;
        logic [31:0] s32;
        m  = longint'(1) << w;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        if (s) begin
            ru = ua - ub;
            c  = (ua >= ub);
            rs = sa - sb;
        end else begin
            ru = ua + ub;
            c  = (ru >= m);
            rs = sa + sb;
        end
        o   = (rs < -(m / 2)) || (rs >= m / 2);
        s32 = 32'(((ru % m) + m) % m);
        return {o, c, s32};
    endfunction

    task automatic drive(input int which, input logic [31:0] ta, input logic [31:0] tb, input bit ts);
        case (which)
            0: begin a8  = ta[7:0]; b8  = tb[7:0]; sub[0] = ts; start[0] = 1'b1; end
            1: begin a8n = ta[7:0]; b8n = tb[7:0]; sub[1] = ts; start[1] = 1'b1; end
            default: begin a2 = ta[1:0]; b2 = tb[1:0]; sub[2] = ts; start[2] = 1'b1; end
        endcase
    endtask

    task automatic sample(input int which, output logic bsy, output logic dn,
                          output logic c, output logic o, output logic [31:0] sm);
        bsy = busy[which];
        dn  = done[which];
        c   = carry[which];
        o   = ovf[which];
        case (which)
            0:       sm = {24'd0, sum8};
            1:       sm = {24'd0, sum8n};
            default: sm = {30'd0, sum2};
        endcase
    endtask

    // Waits for done, counting negedges from the negedge start was driven on.
    // Done is expected on the negedge after the WIDTH-th edge past acceptance,
    // i.e. n == WIDTH + 1. Also checks the old result is held once running.
    task automatic wait_done(input int which, output int n);
        logic bsy, dn, c, o;
        logic [31:0] sm;
        n  = 0;
        dn = 1'b0;
        while (!dn && n < 64) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 3'b000;
            sample(which, bsy, dn, c, o, sm);
            if (n == 1) begin
                check_eq("busy_after_accept", {63'd0, bsy}, 64'd1);
                check_eq("sum_held_in_run", {32'd0, sm}, {32'd0, last_sum[which]});
            end
        end
    endtask

    task automatic run_op(input int which, input logic [31:0] ta, input logic [31:0] tb,
                          input bit ts, input string tag);
        int n, w;
        logic bsy, dn, c, o;
        logic [31:0] sm, mask;
        logic [33:0] exp;
        bit sub_en;
        w      = width_of(which);
        sub_en = (which != 1);
        mask   = (32'd1 << w) - 32'd1;
        exp    = ref_model(w, longint'(ta & mask), longint'(tb & mask), ts & sub_en);
        drive(which, ta, tb, ts);
        wait_done(which, n);
        sample(which, bsy, dn, c, o, sm);
        check_eq({tag, "_latency"}, 64'(n), 64'(w + 1));
        check_eq({tag, "_busy_low"}, {63'd0, bsy}, 64'd0);
        check_eq({tag, "_sum"}, {32'd0, sm}, {32'd0, exp[31:0]});
        check_eq({tag, "_carry"}, {63'd0, c}, {63'd0, exp[32]});
        check_eq({tag, "_ovf"}, {63'd0, o}, {63'd0, exp[33]});
        last_sum[which] = exp[31:0];
    endtask

    initial begin
        int n, dn_cnt;
        logic bsy, dn, c, o;
        logic [31:0] sm;

        rst = 1'b1; start = 3'b000; sub = 3'b000;
        a8 = 8'd0; b8 = 8'd0; a8n = 8'd0; b8n = 8'd0; a2 = 2'd0; b2 = 2'd0;
        for (int i = 0; i < 3; i++) last_sum[i] = 32'd0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sample(i, bsy, dn, c, o, sm);
            check_eq("reset_busy", {63'd0, bsy}, 64'd0);
            check_eq("reset_done", {63'd0, dn}, 64'd0);
            check_eq("reset_sum", {32'd0, sm}, 64'd0);
            check_eq("reset_flags", {62'd0, c, o}, 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(0, 32'h0F, 32'h01, 1'b0, "add_0f_01");
        run_op(0, 32'hFF, 32'h01, 1'b0, "add_ff_01");
        run_op(0, 32'h7F, 32'h01, 1'b0, "add_7f_01");
        run_op(0, 32'h05, 32'h07, 1'b1, "sub_05_07");
        run_op(0, 32'h80, 32'h01, 1'b1, "sub_80_01");
        run_op(1, 32'h05, 32'h07, 1'b1, "nosub_05_07");
        check_eq("nosub_sum_0c", {56'd0, sum8n}, 64'h0C);

        // start pulses and operand changes during a run are ignored.
        @(negedge clk);
        drive(0, 32'h33, 32'h11, 1'b0);
        n = 0; dn = 1'b0;
        while (!dn && n < 64) begin
            @(negedge clk);
            n++;
            sample(0, bsy, dn, c, o, sm);
            if (!dn) begin
                start[0] = (n == 2 || n == 5);
                a8 = 8'($urandom); b8 = 8'($urandom); sub[0] = 1'($urandom);
            end
        end
        check_eq("ignore_latency", 64'(n), 64'd9);
        check_eq("ignore_sum", {32'd0, sm}, 64'h44);
        check_eq("ignore_flags", {62'd0, c, o}, 64'd0);
        last_sum[0] = 32'h44;

        // Back-to-back: second start issued in the done cycle.
        @(negedge clk);
        run_op(0, 32'h20, 32'h22, 1'b0, "b2b_first");
        run_op(0, 32'h10, 32'h05, 1'b1, "b2b_second");

        // Reset in the middle of a run.
        @(negedge clk);
        drive(0, 32'h55, 32'h22, 1'b0);
        @(negedge clk); start = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        sample(0, bsy, dn, c, o, sm);
        check_eq("midrst_busy", {63'd0, bsy}, 64'd0);
        check_eq("midrst_done", {63'd0, dn}, 64'd0);
        check_eq("midrst_sum", {32'd0, sm}, 64'd0);
        check_eq("midrst_flags", {62'd0, c, o}, 64'd0);
        rst = 1'b0;
        dn_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done[0]) dn_cnt++;
        end
        check_eq("midrst_no_done", 64'(dn_cnt), 64'd0);
        for (int i = 0; i < 3; i++) last_sum[i] = 32'd0;
        run_op(0, 32'h12, 32'h34, 1'b0, "post_rst_add");

        // Randomised operations.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            run_op(0, $urandom, $urandom, 1'($urandom), "rand8");
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            run_op(1, $urandom, $urandom, 1'($urandom), "rand8_nosub");
        end

        // WIDTH 2 exhaustive.
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    @(negedge clk);
                    run_op(2, 32'(x), 32'(y), s[0], "w2_exh");
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
